multi_cycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the processor datapath.
- Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Fetches over a req/ack handshake with instruction memory and latches the instruction.
- Registers the decoded datapath controls, pulses register write and PC advance once per instruction, and counts retired instructions.

---
 rtl/multi_cycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_sequencer.sv
// ============================================================================
// Module      : multi_cycle_sequencer
// Description : FETCH/DECODE/EXECUTE/WRITEBACK control sequencer with a timed
//               imem req/ack fetch, registered decode and a retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32,
  parameter logic [31:0] HALT_CODE     = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             imm_sel,
  output logic             alu_src,
  output logic             alu_class,
  output logic [5:0]       funct,
  output logic             alu_en,
  output logic             reg_write,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] C_ST_IDLE      = 3'd0;
  localparam logic [2:0] C_ST_FETCH     = 3'd1;
  localparam logic [2:0] C_ST_DECODE    = 3'd2;
  localparam logic [2:0] C_ST_EXECUTE   = 3'd3;
  localparam logic [2:0] C_ST_WRITEBACK = 3'd4;
  localparam logic [2:0] C_ST_HALT      = 3'd5;
  localparam logic [2:0] C_ST_ERROR     = 3'd6;

  // Counter only needs to reach FETCH_TIMEOUT-1: the last no-ack cycle exits.
  localparam int unsigned       C_TO_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(FETCH_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              imm_sel_q, imm_sel_d;
  logic              alu_src_q, alu_src_d;
  logic              alu_class_q, alu_class_d;
  logic [5:0]        funct_q, funct_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE:      if (start) state_d = C_ST_FETCH;
      C_ST_FETCH: begin
        if (imem_ack) begin
          state_d = C_ST_DECODE;
        end else if (to_cnt_q == C_TO_LAST) begin
          state_d = C_ST_ERROR;
        end
      end
      C_ST_DECODE:    state_d = (instr_q == HALT_CODE) ? C_ST_HALT : C_ST_EXECUTE;
      C_ST_EXECUTE:   state_d = C_ST_WRITEBACK;
      C_ST_WRITEBACK: state_d = stop ? C_ST_IDLE : C_ST_FETCH;
      C_ST_HALT:      state_d = C_ST_HALT;
      C_ST_ERROR:     state_d = C_ST_ERROR;
      default:        state_d = C_ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == C_ST_FETCH);
    alu_en    = (state_q == C_ST_EXECUTE);
    reg_write = (state_q == C_ST_WRITEBACK);
    pc_en     = (state_q == C_ST_WRITEBACK);
    busy      = (state_q == C_ST_FETCH)   || (state_q == C_ST_DECODE) ||
                (state_q == C_ST_EXECUTE) || (state_q == C_ST_WRITEBACK);
    halted    = (state_q == C_ST_HALT);
    fetch_err = (state_q == C_ST_ERROR);
  end

  // Datapath next-state: instruction capture, decode, timeout and retire count.
  always_comb begin
    instr_d     = instr_q;
    imm_sel_d   = imm_sel_q;
    alu_src_d   = alu_src_q;
    alu_class_d = alu_class_q;
    funct_d     = funct_q;
    instret_d   = instret_q;
    to_cnt_d    = '0;

    if (state_q == C_ST_FETCH) begin
      if (imem_ack) begin
        instr_d = imem_rdata;
      end else begin
        to_cnt_d = to_cnt_q + C_TO_W'(1);
      end
    end

    if (state_q == C_ST_DECODE) begin
      imm_sel_d   = ~instr_q[26];
      alu_src_d   = ~(instr_q[5] ^ instr_q[4]) | instr_q[26];
      alu_class_d = instr_q[26];
      funct_d     = instr_q[5:0];
    end

    if (state_q == C_ST_WRITEBACK) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q    <= '0;
      instr_q     <= '0;
      imm_sel_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_class_q <= 1'b0;
      funct_q     <= '0;
      instret_q   <= '0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      instr_q     <= instr_d;
      imm_sel_q   <= imm_sel_d;
      alu_src_q   <= alu_src_d;
      alu_class_q <= alu_class_d;
      funct_q     <= funct_d;
      instret_q   <= instret_d;
    end
  end

  assign instr     = instr_q;
  assign imm_sel   = imm_sel_q;
  assign alu_src   = alu_src_q;
  assign alu_class = alu_class_q;
  assign funct     = funct_q;
  assign instret   = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_sequencer.sv
// ============================================================================
// Module      : tb_multi_cycle_sequencer
// Description : Scoreboard bench for multi_cycle_sequencer; expected retirements
//               are queued at issue and checked on every reg_write pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_sequencer;

  localparam int unsigned FT = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          imem_req;
  logic [31:0]   instr;
  logic          imm_sel, alu_src, alu_class;
  logic [5:0]    funct;
  logic          alu_en, reg_write, pc_en, busy, halted, fetch_err;
  logic [CW-1:0] instret;

  multi_cycle_sequencer #(
    .FETCH_TIMEOUT(FT),
    .CNT_W        (CW),
    .HALT_CODE    (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instr     (instr),
    .imm_sel   (imm_sel),
    .alu_src   (alu_src),
    .alu_class (alu_class),
    .funct     (funct),
    .alu_en    (alu_en),
    .reg_write (reg_write),
    .pc_en     (pc_en),
    .busy      (busy),
    .halted    (halted),
    .fetch_err (fetch_err),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  dec;   // {imm_sel, alu_src, alu_class}
    logic [5:0]  fn;
    int          cnt;   // instret value visible during WRITEBACK
    int          nreq;  // FETCH cycles for this instruction
  } exp_t;

  // Hand-decoded instruction vectors.
  logic [31:0] vw [6] = '{32'h0400_0005, 32'h0000_0020, 32'h0000_0030,
                          32'h0000_0010, 32'h0000_0000, 32'h0400_0020};
  logic [2:0]  vd [6] = '{3'b011, 3'b100, 3'b110, 3'b100, 3'b110, 3'b011};
  logic [5:0]  vf [6] = '{6'h05, 6'h20, 6'h30, 6'h10, 6'h00, 6'h20};

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_chk = 0, n_pass = 0;
  int          wb_seen = 0, alu_seen = 0, pc_seen = 0;
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          exp_instret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input int nreq);
    exp_t e;
    e.word = vw[idx];
    e.dec  = vd[idx];
    e.fn   = vf[idx];
    e.cnt  = exp_instret;
    e.nreq = nreq;
    sb.push_back(e);
    prog.push_back(vw[idx]);
    exp_instret = (exp_instret + 1) % (1 << CW);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_reach_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_wb(input string nm, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wb_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_wb_count"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_decode"}, 32'({imm_sel, alu_src, alu_class, funct}), 32'h0);
    chk({nm, "_ctrl"}, 32'({alu_en, reg_write, pc_en, busy, halted, fetch_err, imem_req}), 32'h0);
    chk({nm, "_instret"}, 32'(instret), 32'h0);
  endtask

  // Instruction memory model: ack after ack_delay wait cycles while words remain.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
      end else if (imem_req) begin
        if (prog.size() > 0 && wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = prog.pop_front();
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every reg_write pulse retires the oldest queued expectation.
  initial begin
    int   req_cnt = 0;
    int   first_cyc = 0;
    int   cyc = 0;
    logic prev_alu = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        req_cnt  = 0;
        prev_alu = 1'b0;
      end else begin
        if (alu_en) alu_seen++;
        if (pc_en) pc_seen++;
        if (imem_req) begin
          if (req_cnt == 0) first_cyc = cyc;
          req_cnt++;
        end
        if (reg_write) begin
          wb_seen++;
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_wb: got reg_write=1 expected no retirement (instr %h)", instr);
          end else begin
            e = sb.pop_front();
            chk("wb_instr", instr, e.word);
            chk("wb_decode", 32'({imm_sel, alu_src, alu_class}), 32'(e.dec));
            chk("wb_funct", 32'(funct), 32'(e.fn));
            chk("wb_instret", 32'(instret), e.cnt);
            chk("wb_pulses", 32'({prev_alu, alu_en, pc_en}), 32'b101);
            chk("wb_fetch_cycles", req_cnt, e.nreq);
            chk("wb_latency", cyc - first_cyc + 1, e.nreq + 3);
          end
          req_cnt = 0;
        end
        prev_alu = alu_en;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nreq, c, a0, w0, p0;
    bit ok;

    reset = 1'b1;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    step();

    // Single instruction, immediate ack, stop returns to IDLE.
    ack_delay = 0;
    push_exp(0, 1);
    stop  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t1");
    chk("t1_instret", 32'(instret), exp_instret);

    // Three back-to-back R-type words.
    stop = 1'b0;
    push_exp(1, 1);
    push_exp(1, 1);
    push_exp(1, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_wb("t2", wb_seen + 2);
    stop = 1'b1;
    wait_idle("t2");
    chk("t2_instret", 32'(instret), exp_instret);

    // Ack delayed 3 cycles, then ack on the very last timeout cycle.
    ack_delay = 3;
    push_exp(2, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t3");
    chk("t3_fetch_err", 32'(fetch_err), 32'd0);
    ack_delay = FT - 1;
    push_exp(3, FT);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t3b");
    chk("t3b_fetch_err", 32'(fetch_err), 32'd0);
    chk("t3b_instret", 32'(instret), exp_instret);

    // No ack at all: ERROR after FT fetch cycles.
    ack_delay = 0;
    w0 = wb_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      if (fetch_err) break;
      if (imem_req) nreq++;
      step();
    end
    chk("t4_fetch_cycles", nreq, FT);
    chk("t4_fetch_err", 32'(fetch_err), 32'd1);
    step();
    step();
    chk("t4_error_outputs", 32'({imem_req, busy, fetch_err}), 32'b001);
    chk("t4_no_wb", wb_seen, w0);
    do_reset();
    chk_idle("t4_reset");

    // HALT word: halts after DECODE, ignores everything afterwards.
    prog.push_back(32'hFFFF_FFFF);
    stop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    a0 = alu_seen;
    w0 = wb_seen;
    p0 = pc_seen;
    c  = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted) break;
      step();
      c++;
    end
    chk("t5_halt_cycle", c, 2);
    chk("t5_instr", instr, 32'hFFFF_FFFF);
    chk("t5_decode", 32'({imm_sel, alu_src, alu_class, funct}), 32'({3'b011, 6'h3F}));
    force_ack = 1'b1;
    start     = 1'b1;
    stop      = 1'b1;
    for (int i = 0; i < 5; i++) step();
    force_ack = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    chk("t5_halt_outputs", 32'({halted, busy, imem_req, fetch_err}), 32'b1000);
    chk("t5_instr_hold", instr, 32'hFFFF_FFFF);
    chk("t5_no_pulses", alu_seen + wb_seen + pc_seen, a0 + w0 + p0);
    do_reset();
    chk_idle("t5_reset");

    // Reset during EXECUTE abandons the instruction.
    prog.push_back(vw[4]);
    start = 1'b1;
    step();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (alu_en) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("t6_reach_execute", 32'(ok), 32'd1);
    w0 = wb_seen;
    do_reset();
    chk("t6_after_reset", 32'({busy, reg_write, pc_en}), 32'h0);
    chk("t6_instret", 32'(instret), 32'h0);
    step();
    step();
    step();
    chk("t6_no_wb", wb_seen, w0);
    chk("t6_idle", 32'(busy), 32'h0);

    // 2^CW retirements wrap instret to 0, last one with stop.
    w0 = wb_seen;
    for (int i = 0; i < (1 << CW); i++) push_exp(i % 6, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_wb("t7", w0 + (1 << CW) - 1);
    stop = 1'b1;
    wait_idle("t7");
    chk("t7_instret_wrap", 32'(instret), 32'h0);
    chk("t7_retired", wb_seen - w0, 1 << CW);

    step();
    step();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
